lantian_phy_manager: RTL and testbench

- Sequences and shares the MDIO management master between the Nios CPU and an autonomous PHY supervisor.
- After reset it writes a boot configuration into PHY BMCR, then polls BMSR (reg 1) and the PHY-specific status register (reg 17) every POLL_INTERVAL cycles.
- It publishes link, speed and duplex to the MAC.
- CPU MDIO accesses are forwarded through the same master port, arbitrated against polling.

---
 rtl/lantian_phy_manager.sv | 183 ++++++++++++++++++
 tb/tb_lantian_phy_manager.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lantian_phy_manager.sv
// MDIO management sequencer: boots the PHY, polls link status and
// shares the MDIO master between the CPU and the autonomous poller.
module lantian_phy_manager #(
    parameter int unsigned POLL_INTERVAL = 2500000,
    parameter logic [15:0] BOOT_BMCR     = 16'h1200,
    parameter logic [4:0]  PHYSR_ADDR    = 5'd17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic [4:0]  m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        full_duplex,
    output logic        init_done
);

    localparam int unsigned TW = $clog2(POLL_INTERVAL);
    localparam logic [TW-1:0] RELOAD = TW'(POLL_INTERVAL - 1);

    typedef enum logic [3:0] {
        BOOT_WR, BOOT_GAP, IDLE, CPU_XFER, CPU_ACK,
        RD_BMSR, GAP1, RD_PHYSR, GAP2
    } state_e;

    state_e        state_q, state_d;
    logic          m_read_q, m_read_d;
    logic          m_write_q, m_write_d;
    logic [4:0]    m_addr_q, m_addr_d;
    logic [15:0]   m_wdata_q, m_wdata_d;
    logic          link_q, link_d;
    logic [1:0]    speed_q, speed_d;
    logic          dup_q, dup_d;
    logic          init_q, init_d;
    logic [15:0]   cpu_rdata_q, cpu_rdata_d;
    logic          cpu_wait_q, cpu_wait_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          poll_q, poll_d;
    logic          done;

    logic unused_hi;
    assign unused_hi = ^{cpu_writedata[31:16], m_readdata[31:16]};

    // A transfer completes on the edge that sees the slave release waitrequest.
    assign done = (m_read_q | m_write_q) & ~m_waitrequest;

    always_comb begin
        state_d     = state_q;
        m_read_d    = m_read_q;
        m_write_d   = m_write_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        link_d      = link_q;
        speed_d     = speed_q;
        dup_d       = dup_q;
        init_d      = init_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_wait_d  = cpu_wait_q;
        poll_d      = poll_q;
        timer_d     = (timer_q == '0) ? RELOAD : timer_q - TW'(1);

        unique case (state_q)
            BOOT_WR: begin
                if (!m_write_q) begin
                    m_write_d = 1'b1;
                    m_addr_d  = 5'd0;
                    m_wdata_d = BOOT_BMCR;
                end else if (done) begin
                    m_write_d = 1'b0;
                    init_d    = 1'b1;
                    state_d   = BOOT_GAP;
                end
            end
            BOOT_GAP: state_d = IDLE;
            IDLE: begin
                if ((cpu_read | cpu_write) && init_q) begin
                    m_read_d  = cpu_read;
                    m_write_d = ~cpu_read;
                    m_addr_d  = cpu_address;
                    m_wdata_d = cpu_writedata[15:0];
                    state_d   = CPU_XFER;
                end else if (poll_q) begin
                    poll_d   = 1'b0;
                    m_read_d = 1'b1;
                    m_addr_d = 5'd1;
                    state_d  = RD_BMSR;
                end
            end
            CPU_XFER: begin
                if (done) begin
                    if (m_read_q) cpu_rdata_d = m_readdata[15:0];
                    m_read_d   = 1'b0;
                    m_write_d  = 1'b0;
                    cpu_wait_d = 1'b0;
                    state_d    = CPU_ACK;
                end
            end
            CPU_ACK: begin
                cpu_wait_d = 1'b1;
                state_d    = IDLE;
            end
            RD_BMSR: begin
                if (done) begin
                    m_read_d = 1'b0;
                    link_d   = m_readdata[2];
                    state_d  = m_readdata[2] ? GAP1 : GAP2;
                end
            end
            GAP1: begin
                m_read_d = 1'b1;
                m_addr_d = PHYSR_ADDR;
                state_d  = RD_PHYSR;
            end
            RD_PHYSR: begin
                if (done) begin
                    m_read_d = 1'b0;
                    speed_d  = m_readdata[15:14];
                    dup_d    = m_readdata[13];
                    state_d  = GAP2;
                end
            end
            GAP2: state_d = IDLE;
            default: state_d = BOOT_WR;
        endcase

        // A fresh expiry outranks consumption so it is never lost.
        if (timer_q == '0) poll_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BOOT_WR;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            link_q      <= 1'b0;
            speed_q     <= '0;
            dup_q       <= 1'b0;
            init_q      <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_wait_q  <= 1'b1;
            timer_q     <= RELOAD;
            poll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            link_q      <= link_d;
            speed_q     <= speed_d;
            dup_q       <= dup_d;
            init_q      <= init_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_wait_q  <= cpu_wait_d;
            timer_q     <= timer_d;
            poll_q      <= poll_d;
        end
    end

    assign m_read          = m_read_q;
    assign m_write         = m_write_q;
    assign m_address       = m_addr_q;
    assign m_writedata     = {16'b0, m_wdata_q};
    assign link_up         = link_q;
    assign speed           = speed_q;
    assign full_duplex     = dup_q;
    assign init_done       = init_q;
    assign cpu_readdata    = {16'b0, cpu_rdata_q};
    assign cpu_waitrequest = cpu_wait_q;

endmodule

// File: tb/tb_lantian_phy_manager.sv
// Bench for lantian_phy_manager: MDIO slave model, transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_lantian_phy_manager;

    localparam int P = 200;
    localparam int NEVER = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata, cpu_readdata;
    logic        cpu_waitrequest;
    logic [4:0]  m_address;
    logic        m_read, m_write;
    logic [31:0] m_writedata, m_readdata;
    logic        m_waitrequest;
    logic        link_up, full_duplex, init_done;
    logic [1:0]  speed;

    lantian_phy_manager #(.POLL_INTERVAL(P)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_address(cpu_address), .cpu_read(cpu_read),
        .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest),
        .link_up(link_up), .speed(speed), .full_duplex(full_duplex),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level) -------------
    int          n, boot_at, phys_at, decide_at, kind;
    bit          pend, req, req_rd;
    logic [4:0]  req_addr;
    logic [31:0] req_wd;
    bit          e_link, e_dup, e_init, e_cwait;
    logic [1:0]  e_spd;
    logic [31:0] e_rdata;

    task automatic model_reset();
        n = 0; boot_at = 0; phys_at = -1; decide_at = NEVER;
        pend = 0; req = 0; kind = 0;
        e_link = 0; e_dup = 0; e_init = 0; e_cwait = 1;
        e_spd = 0; e_rdata = 0;
    endtask

    task automatic start(input int k, input bit rd, input logic [4:0] a,
                         input logic [31:0] wd);
        req = 1; kind = k; req_rd = rd; req_addr = a; req_wd = wd;
        decide_at = NEVER;
    endtask

    // One clock edge, using the inputs the DUT sampled on it.
    task automatic model_edge();
        bit expire, consumed;
        expire = (n % P) == P - 1;
        consumed = 0;
        e_cwait = 1;
        if (req) begin
            if (!m_waitrequest) begin
                req = 0;
                decide_at = n + 2;
                case (kind)
                    0: e_init = 1;
                    1: begin
                        if (req_rd) e_rdata = {16'h0, m_readdata[15:0]};
                        e_cwait = 0;
                    end
                    2: begin
                        e_link = m_readdata[2];
                        if (m_readdata[2]) begin
                            phys_at = n + 1;
                            decide_at = NEVER;
                        end
                    end
                    default: begin
                        e_spd = m_readdata[15:14];
                        e_dup = m_readdata[13];
                    end
                endcase
            end
        end else if (n == boot_at) begin
            start(0, 0, 5'd0, 32'h1200);
            boot_at = -1;
        end else if (n == phys_at) begin
            start(3, 1, 5'd17, req_wd);
            phys_at = -1;
        end else if (n >= decide_at) begin
            if (cpu_read || cpu_write)
                start(1, cpu_read, cpu_address, {16'h0, cpu_writedata[15:0]});
            else if (pend) begin
                start(2, 1, 5'd1, req_wd);
                consumed = 1;
            end
        end
        if (expire) pend = 1;
        else if (consumed) pend = 0;
        n++;
    endtask

    task automatic compare();
        chk("m_read", 32'(m_read), 32'(req && req_rd));
        chk("m_write", 32'(m_write), 32'(req && !req_rd));
        if (req) chk("m_address", 32'(m_address), 32'(req_addr));
        if (req && !req_rd) chk("m_writedata", m_writedata, req_wd);
        chk("link_up", 32'(link_up), 32'(e_link));
        chk("speed", 32'(speed), 32'(e_spd));
        chk("full_duplex", 32'(full_duplex), 32'(e_dup));
        chk("init_done", 32'(init_done), 32'(e_init));
        chk("cpu_readdata", cpu_readdata, e_rdata);
        chk("cpu_waitrequest", 32'(cpu_waitrequest), 32'(e_cwait));
    endtask

    // ---------------- MDIO slave model --------------------------------
    typedef struct {
        bit         wr;
        logic [4:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        log_q[$];
    logic [15:0] regs[32];
    int          fixed_lat, s_cnt, n_physr, n_bmsr;
    bit          s_busy, s_wr;
    logic [4:0]  s_addr;
    logic [15:0] s_wd;

    task automatic slave_reset();
        m_waitrequest = 1; m_readdata = 0; s_busy = 0;
    endtask

    task automatic slave_step();
        txn_t t;
        if (!m_waitrequest) begin
            m_waitrequest = 1;
            s_busy = 0;
            if (s_wr) regs[s_addr] = s_wd;
            t.wr = s_wr; t.addr = s_addr;
            t.data = s_wr ? s_wd : regs[s_addr];
            log_q.push_back(t);
            if (!s_wr && s_addr == 5'd17) n_physr++;
            if (!s_wr && s_addr == 5'd1) n_bmsr++;
            m_readdata = $urandom;
        end else begin
            m_readdata = $urandom;
            if (!s_busy && (m_read || m_write)) begin
                s_busy = 1; s_wr = m_write; s_addr = m_address;
                s_wd = m_writedata[15:0];
                s_cnt = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 6);
            end
            if (s_busy) begin
                if (s_cnt == 0) begin
                    m_waitrequest = 0;
                    m_readdata = {16'($urandom), regs[s_addr]};
                end else s_cnt--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_edge();
        compare();
        slave_step();
    endtask

    task automatic cpu_op(input bit rd, input logic [4:0] a,
                          input logic [15:0] d, output logic [31:0] got);
        bit acked = 0;
        cpu_read = rd; cpu_write = !rd; cpu_address = a;
        cpu_writedata = {16'($urandom), d};
        for (int i = 0; i < 2000 && !acked; i++) begin
            step();
            acked = !cpu_waitrequest;
        end
        chk("cpu_ack_seen", 32'(acked), 32'd1);
        cpu_read = 0; cpu_write = 0;
        got = cpu_readdata;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_m_read"}, 32'(m_read), 0);
        chk({tag, "_m_write"}, 32'(m_write), 0);
        chk({tag, "_m_addr"}, 32'(m_address), 0);
        chk({tag, "_m_wd"}, m_writedata, 0);
        chk({tag, "_link"}, 32'(link_up), 0);
        chk({tag, "_speed"}, 32'(speed), 0);
        chk({tag, "_dup"}, 32'(full_duplex), 0);
        chk({tag, "_init"}, 32'(init_done), 0);
        chk({tag, "_rdata"}, cpu_readdata, 0);
        chk({tag, "_cwait"}, 32'(cpu_waitrequest), 1);
    endtask

    initial begin
        logic [31:0] got;
        logic [15:0] expv;
        int nb, np, sz;
        bit ok;

        reset_n = 0;
        cpu_read = 0; cpu_write = 0; cpu_address = 0; cpu_writedata = 0;
        foreach (regs[i]) regs[i] = 16'($urandom);
        regs[1] = 16'h796D; regs[17] = 16'hAC00; regs[2] = 16'h0141;
        n_physr = 0; n_bmsr = 0;
        fixed_lat = 100;
        slave_reset();
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        reset_n = 1;

        // Boot write with a slow slave
        for (int i = 0; i < 300 && log_q.size() == 0; i++) step();
        chk("boot_logged", 32'(log_q.size()), 1);
        if (log_q.size() > 0) begin
            chk("boot_wr", 32'(log_q[0].wr), 1);
            chk("boot_addr", 32'(log_q[0].addr), 0);
            chk("boot_data", 32'(log_q[0].data), 32'h1200);
        end
        chk("boot_init", 32'(init_done), 1);
        fixed_lat = -1;

        // Link up poll round
        for (int i = 0; i < 600 && n_physr == 0; i++) step();
        chk("s2_physr_seen", 32'(n_physr), 1);
        sz = log_q.size();
        chk("s2_prev_addr", 32'(log_q[sz-2].addr), 1);
        chk("s2_link", 32'(link_up), 1);
        chk("s2_speed", 32'(speed), 32'h2);
        chk("s2_dup", 32'(full_duplex), 1);
        chk("s2_model_speed", 32'(e_spd), 32'h2);

        // Link down: speed/duplex retained, no reg 17 read
        regs[1] = 16'h7969;
        np = n_physr; nb = n_bmsr;
        for (int i = 0; i < 900 && n_bmsr < nb + 2; i++) step();
        chk("s3_rounds", 32'(n_bmsr >= nb + 2), 1);
        chk("s3_link", 32'(link_up), 0);
        chk("s3_speed", 32'(speed), 32'h2);
        chk("s3_dup", 32'(full_duplex), 1);
        chk("s3_no_physr", 32'(n_physr), 32'(np));

        // CPU read
        cpu_op(1, 5'd2, 16'h0, got);
        chk("s4_rdata", got, 32'h0000_0141);
        step();
        chk("s4_wait_back", 32'(cpu_waitrequest), 1);

        // CPU write issued during an in-flight BMSR poll
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            step();
            ok = req && kind == 2;
        end
        chk("s5_bmsr_inflight", 32'(ok), 1);
        fixed_lat = 250;
        cpu_op(0, 5'd4, 16'h01E1, got);
        fixed_lat = -1;
        sz = log_q.size();
        chk("s5_wr_last", 32'(log_q[sz-1].wr), 1);
        chk("s5_wr_addr", 32'(log_q[sz-1].addr), 4);
        chk("s5_wr_data", 32'(log_q[sz-1].data), 32'h01E1);
        chk("s5_poll_first", 32'(log_q[sz-2].addr), 1);
        chk("s5_reg4", 32'(regs[4]), 32'h01E1);
        for (int i = 0; i < 600 && log_q.size() == sz; i++) step();
        chk("s5_poll_after", 32'(log_q.size() > sz), 1);
        if (log_q.size() > sz)
            chk("s5_poll_after_addr", 32'(log_q[sz].addr), 1);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            regs[1] = 16'($urandom);
            regs[17] = 16'($urandom);
            repeat ($urandom_range(0, 250)) step();
            if ($urandom_range(0, 1) == 1) begin
                logic [4:0] a;
                a = 5'($urandom);
                expv = regs[a];
                if ($urandom_range(0, 1) == 1) begin
                    cpu_op(1, a, 16'h0, got);
                    chk("rnd_cpu_read", got, {16'h0, expv});
                end else begin
                    cpu_op(0, a, 16'($urandom), got);
                end
                step();
            end
        end

        // Reset during RD_PHYSR
        regs[1] = 16'h796D; regs[17] = 16'h6000;
        fixed_lat = 30;
        ok = 0;
        for (int i = 0; i < 900 && !ok; i++) begin
            step();
            ok = req && kind == 3;
        end
        chk("s6_physr_inflight", 32'(ok), 1);
        repeat (5) step();
        chk("s6_m_read_before", 32'(m_read), 1);
        #2 reset_n = 0;
        #1 chk_reset_outs("midreset");
        model_reset();
        slave_reset();
        log_q.delete();
        fixed_lat = 10;
        repeat (3) @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 300 && log_q.size() == 0; i++) step();
        chk("s6_reboot_logged", 32'(log_q.size()), 1);
        if (log_q.size() > 0) begin
            chk("s6_reboot_wr", 32'(log_q[0].wr), 1);
            chk("s6_reboot_addr", 32'(log_q[0].addr), 0);
            chk("s6_reboot_data", 32'(log_q[0].data), 32'h1200);
        end
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
